seq_multiplier: RTL
===================

# seq_multiplier

Parametrised, iterative shift-add multiplier with a start/done handshake and run-time selectable signed or unsigned operation. It computes a full-width 2·WIDTH-bit product and takes one partial-product addition per clock, so an N×N multiply costs N adder bits of area instead of N² cells. The block sits beside the combinational array multiplier in the arithmetic library. Datapath stages use it where area matters more than single-cycle latency.

## Interface
- WIDTH, default 8: operand width in bits, minimum 2; the product is 2·WIDTH bits.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  request to multiply; sampled on the clock edge and accepted only when busy=0.
- signed_mode  in  1  0 = unsigned operands, 1 = two's-complement operands; captured with the operands.
- a  in  WIDTH  multiplicand; captured on the accepting edge.
- b  in  WIDTH  multiplier; captured on the accepting edge.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse when m holds a new result.
- m  out  2·WIDTH  product; holds its value until the next completion.

## Operation
- States:
  - IDLE → RUN on an edge with start=1.
  - RUN → FINISH after WIDTH iteration edges.
  - FINISH → IDLE on the next edge.
- Capture (IDLE with start=1):
  - latch signed_mode;
  - latch |a| and |b| as unsigned WIDTH-bit magnitudes;
  - latch neg = signed_mode & (a[MSB] ^ b[MSB]);
  - clear accumulator (2·WIDTH+1 bits) and iteration counter.
- In unsigned mode the magnitude is the operand unchanged.
- The signed minimum magnitude (e.g. -128 → 128 for WIDTH=8) is represented exactly.
- RUN, each edge:
  - if the current LSB of the multiplier shift register is 1, add the multiplicand magnitude into the upper half of the accumulator, carry kept;
  - shift the accumulator right by 1 and the multiplier register right by 1;
  - increment the counter.
- FINISH edge:
  - m ← neg ? -acc : acc, truncated to 2·WIDTH bits;
  - done ← 1;
  - busy ← 0.
- Width rules:
  - unsigned range 0 … (2^WIDTH−1)²;
  - signed range −2^(WIDTH−1)·(2^(WIDTH−1)−1) … 2^(2·WIDTH−2);
  - both ranges fit 2·WIDTH bits, so no overflow is possible.
  - A zero result with neg=1 gives m=0.
- start while busy=1 is ignored: no queueing and no effect on the operation in flight.
- a, b and signed_mode may change freely after the accepting edge.

## Timing
- Reset values: busy=0, done=0, m=0, state IDLE, counter 0.
- Reset asserted mid-operation aborts it on that edge:
  - no done pulse;
  - m returns to 0;
  - start is ignored during the reset cycle.
- Latency:
  - start is sampled at edge T;
  - busy=1 from after edge T through edge T+WIDTH+1;
  - done=1 and the new m are visible for exactly one cycle after edge T+WIDTH+1.
- done is high the cycle after the FINISH edge, when the state is already IDLE and busy=0. A start in the done cycle is therefore accepted.
- Back-to-back throughput is one result per WIDTH+2 cycles.
- m changes only on the FINISH edge or on reset. It is stable during RUN.

## Test plan
- Unsigned, WIDTH=8: a=255, b=255, start at edge T → busy high for 9 cycles; done pulses once after edge T+9; m=0xFE01 until the next completion.
- Signed extremes, WIDTH=8:
  - −128 × −128 → m=0x4000;
  - −128 × 127 → m=0xC080;
  - −1 × 1 → m=0xFFFF;
  - 0 × −5 → m=0x0000.
- Handshake: assert start every cycle, with operands changing every cycle → only operands present on accepting edges are used; results arrive every 10 cycles and each m matches its captured pair.
- Reset mid-operation: start 12×13, assert rst at the 4th RUN cycle → busy=0, done=0 and m=0 after that edge, no done pulse. A new 3×4 start then yields m=12 with normal latency.
- Mode capture: start with signed_mode=1, a=0xFF, b=0x02, then flip signed_mode to 0 the next cycle → m=0xFFFE (−2), not 0x01FE.
- Parameter sweep, WIDTH=4 and WIDTH=16, random operands in both modes, ≥1000 each → m matches the reference model; done appears WIDTH+1 edges after acceptance.

Source files
------------

// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative shift-add multiplier, one partial product per clock,
// signed or unsigned operands selected per operation, start/done handshake.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   m
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  state_t state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand, mplier, a_mag, b_mag;
  logic [2*WIDTH:0] acc;
  logic [WIDTH:0]   sum;
  logic             neg;
  // Magnitudes are unsigned WIDTH bits, so the signed minimum maps exactly to 2^(WIDTH-1).
  assign a_mag = (signed_mode & a[WIDTH-1]) ? -a : a;
  assign b_mag = (signed_mode & b[WIDTH-1]) ? -b : b;
  assign sum   = acc[2*WIDTH:WIDTH] + (mplier[0] ? {1'b0, mcand} : '0);
  always_comb begin
    state_nx = (state == IDLE) ? (start ? RUN : IDLE)
             : (state == RUN)  ? ((cnt == CW'(WIDTH-1)) ? FINISH : RUN)
             : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      m      <= '0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        busy   <= 1'b1;
        mcand  <= a_mag;
        mplier <= b_mag;
        neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
        acc    <= '0;
        cnt    <= '0;
      end else if (state == RUN) begin
        acc    <= {sum, acc[WIDTH-1:0]} >> 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
      end else if (state == FINISH) begin
        m    <= (2*WIDTH)'(neg ? -acc : acc);
        done <= 1'b1;
        busy <= 1'b0;
      end
    end
  end
endmodule
